// File: rtl/parser_match_arbiter.sv
// Packet-atomic round-robin arbiter feeding the shared content-match engine.
// A granted lane keeps the engine until end-of-packet or a stall timeout.
module parser_match_arbiter #(
    parameter int NUM_REQ = 8,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 1023,
    parameter int CNT_W   = 10
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_sop,
    input  logic [NUM_REQ-1:0]        req_eop,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      out_sop,
    output logic                      out_eop,
    output logic                      out_abort,
    output logic [3:0]                out_proto,
    input  logic                      out_ready,
    output logic [NUM_REQ-1:0]        grant,
    output logic [31:0]               pkt_cnt,
    output logic [15:0]               abort_cnt,
    output logic [15:0]               drop_cnt
);
    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, STREAM, ABORT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q, gidx_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [CNT_W-1:0]   tmo_q, tmo_d;
    logic [31:0]        pkt_q, pkt_d;
    logic [15:0]        abort_q, abort_d;
    logic [15:0]        drop_q, drop_d;

    logic               cand_any;
    logic [IDX_W-1:0]   win_idx;
    logic               drop_any;
    logic [IDX_W-1:0]   drop_idx;
    logic               xfer;

    // Round-robin search starting just after the last winner.
    always_comb begin
        logic [NUM_REQ-1:0] cand;
        int j;
        cand     = req_valid & req_sop;
        cand_any = 1'b0;
        win_idx  = '0;
        j        = 0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            j = int'(ptr_q) + i;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!cand_any && cand[j]) begin
                cand_any = 1'b1;
                win_idx  = IDX_W'(j);
            end
        end
    end

    always_comb begin
        logic [NUM_REQ-1:0] stray;
        stray    = req_valid & ~req_sop;
        drop_any = 1'b0;
        drop_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!drop_any && stray[i]) begin
                drop_any = 1'b1;
                drop_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        out_valid = 1'b0;
        out_data  = '0;
        out_sop   = 1'b0;
        out_eop   = 1'b0;
        out_abort = 1'b0;
        out_proto = '0;
        unique case (state_q)
            IDLE: begin
                if (!cand_any && drop_any) req_ready[drop_idx] = 1'b1;
            end
            STREAM: begin
                out_valid         = req_valid[gidx_q];
                out_data          = req_data[int'(gidx_q)*DATA_W +: DATA_W];
                out_sop           = req_sop[gidx_q];
                out_eop           = req_eop[gidx_q];
                out_proto         = 4'(gidx_q);
                req_ready[gidx_q] = out_ready;
            end
            ABORT: begin
                out_valid = 1'b1;
                out_eop   = 1'b1;
                out_abort = 1'b1;
                out_proto = 4'(gidx_q);
            end
            default: ;
        endcase
    end

    assign xfer = req_valid[gidx_q] & out_ready;

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        tmo_d   = tmo_q;
        pkt_d   = pkt_q;
        abort_d = abort_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (cand_any) begin
                    grant_d          = '0;
                    grant_d[win_idx] = 1'b1;
                    gidx_d           = win_idx;
                    ptr_d            = win_idx;
                    state_d          = STREAM;
                end else if (drop_any && drop_q != 16'hffff) begin
                    drop_d = drop_q + 16'd1;
                end
            end
            STREAM: begin
                if (xfer) begin
                    tmo_d = '0;
                    if (req_eop[gidx_q]) begin
                        pkt_d   = pkt_q + 32'd1;
                        grant_d = '0;
                        state_d = IDLE;
                    end
                end else if (!req_valid[gidx_q]) begin
                    tmo_d = tmo_q + 1'b1;
                    if (int'(tmo_d) >= TIMEOUT) state_d = ABORT;
                end
            end
            ABORT: begin
                if (out_ready) begin
                    if (abort_q != 16'hffff) abort_d = abort_q + 16'd1;
                    grant_d = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            tmo_q   <= '0;
            pkt_q   <= '0;
            abort_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            tmo_q   <= tmo_d;
            pkt_q   <= pkt_d;
            abort_q <= abort_d;
            drop_q  <= drop_d;
        end
    end

    assign grant     = grant_q;
    assign pkt_cnt   = pkt_q;
    assign abort_cnt = abort_q;
    assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_parser_match_arbiter.sv
// Directed bench for parser_match_arbiter: lane sources are stepped
// cycle by cycle and the output beat log is checked against hand values.
module tb_parser_match_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [7:0]   req_valid, req_sop, req_eop, req_ready;
    logic [511:0] req_data;
    logic         out_valid, out_sop, out_eop, out_abort, out_ready;
    logic [63:0]  out_data;
    logic [3:0]   out_proto;
    logic [7:0]   grant;
    logic [31:0]  pkt_cnt;
    logic [15:0]  abort_cnt, drop_cnt;

    parser_match_arbiter dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_sop(req_sop), .req_eop(req_eop),
        .req_data(req_data), .req_ready(req_ready),
        .out_valid(out_valid), .out_data(out_data), .out_sop(out_sop),
        .out_eop(out_eop), .out_abort(out_abort), .out_proto(out_proto),
        .out_ready(out_ready), .grant(grant), .pkt_cnt(pkt_cnt),
        .abort_cnt(abort_cnt), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          proto;
        logic [63:0] data;
        bit          sop;
        bit          eop;
        bit          abt;
        int          cyc;
    } beat_t;

    beat_t log_q[$];
    int    lane_len[8], lane_beat[8], lane_npkt[8], lane_pkt[8];
    bit    lane_act[8], lane_hold[8];
    int    cyc = 0;
    int    n_assert = 0;
    int    n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < 8; i++) begin
            req_valid[i] = lane_act[i] && lane_beat[i] < lane_len[i] &&
                           !(lane_hold[i] && lane_beat[i] > 0);
            req_sop[i]   = (lane_beat[i] == 0);
            req_eop[i]   = (lane_beat[i] == lane_len[i] - 1);
            req_data[i*64 +: 64] = {40'h0, 8'(i), 8'(lane_pkt[i]),
                                    8'(lane_beat[i])};
        end
    endtask

    task automatic start(input int i, input int len, input int npkt,
                         input int b0);
        lane_act[i]  = 1'b1;
        lane_hold[i] = 1'b0;
        lane_len[i]  = len;
        lane_npkt[i] = npkt;
        lane_beat[i] = b0;
        lane_pkt[i]  = 0;
    endtask

    task automatic tick();
        logic [7:0] hs;
        bit         ov;
        beat_t      b;
        hs      = req_valid & req_ready;
        ov      = out_valid && out_ready;
        b.proto = int'(out_proto);
        b.data  = out_data;
        b.sop   = out_sop;
        b.eop   = out_eop;
        b.abt   = out_abort;
        b.cyc   = cyc;
        @(posedge clk);
        #1;
        cyc++;
        if (ov) log_q.push_back(b);
        for (int i = 0; i < 8; i++) begin
            if (hs[i]) begin
                lane_beat[i]++;
                if (lane_beat[i] >= lane_len[i]) begin
                    if (lane_npkt[i] > 1) begin
                        lane_npkt[i]--;
                        lane_beat[i] = 0;
                        lane_pkt[i]++;
                    end else begin
                        lane_act[i] = 1'b0;
                    end
                end
            end
        end
        drive();
        #1;
    endtask

    initial begin
        int n;
        int exp_p[9] = '{0, 0, 0, 2, 2, 2, 5, 5, 5};
        rst       = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            lane_act[i]  = 1'b0;
            lane_hold[i] = 1'b0;
            lane_len[i]  = 0;
            lane_beat[i] = 0;
            lane_npkt[i] = 0;
            lane_pkt[i]  = 0;
        end
        drive();
        tick();
        tick();
        rst = 1'b0;
        #1;
        chk("rst_grant", grant, 8'h00);
        chk("rst_ready", req_ready, 8'h00);
        chk("rst_ovalid", out_valid, 1'b0);
        chk("rst_proto", out_proto, 4'h0);
        chk("rst_data", out_data, 64'h0);
        chk("rst_cnts", {pkt_cnt, abort_cnt, drop_cnt}, 64'h0);

        // three simultaneous packets, lane 0 first after reset
        start(0, 3, 1, 0);
        start(2, 3, 1, 0);
        start(5, 3, 1, 0);
        drive();
        #1;
        chk("arb_bubble_ready", req_ready, 8'h00);
        tick();
        chk("t1_grant0", grant, 8'h01);
        chk("t1_sop0", out_sop, 1'b1);
        n = 0;
        while (log_q.size() < 9 && n < 40) begin
            tick();
            n++;
        end
        chk("t1_nbeats", log_q.size(), 9);
        if (log_q.size() == 9) begin
            for (int k = 0; k < 9; k++) begin
                chk("t1_proto", log_q[k].proto, exp_p[k]);
                chk("t1_data", log_q[k].data,
                    {40'h0, 8'(exp_p[k]), 8'h00, 8'(k % 3)});
                chk("t1_sop", log_q[k].sop, (k % 3) == 0);
                chk("t1_eop", log_q[k].eop, (k % 3) == 2);
            end
            chk("t1_contig", log_q[1].cyc - log_q[0].cyc, 1);
            chk("t1_gap", log_q[3].cyc - log_q[2].cyc, 2);
            chk("t1_gap2", log_q[6].cyc - log_q[5].cyc, 2);
        end
        chk("t1_pkt_cnt", pkt_cnt, 32'd3);
        chk("t1_idle_grant", grant, 8'h00);

        // lanes 3 and 4 compete continuously with 1-beat packets
        log_q.delete();
        start(3, 1, 4, 0);
        start(4, 1, 4, 0);
        drive();
        #1;
        n = 0;
        while (log_q.size() < 8 && n < 40) begin
            tick();
            n++;
        end
        chk("t2_nbeats", log_q.size(), 8);
        if (log_q.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk("t2_alt", log_q[k].proto, (k % 2 == 0) ? 3 : 4);
                chk("t2_single", {log_q[k].sop, log_q[k].eop}, 2'b11);
            end
        end
        chk("t2_pkt_cnt", pkt_cnt, 32'd11);

        // lane 1, 6 beats with out_ready toggling
        log_q.delete();
        start(1, 6, 1, 0);
        drive();
        #1;
        n = 0;
        while (log_q.size() < 6 && n < 60) begin
            out_ready = ~out_ready;
            #1;
            if (grant == 8'h02)
                chk("t3_rdy_mirror", req_ready, {6'b0, out_ready, 1'b0});
            tick();
            n++;
        end
        out_ready = 1'b1;
        #1;
        chk("t3_nbeats", log_q.size(), 6);
        if (log_q.size() == 6) begin
            for (int k = 0; k < 6; k++)
                chk("t3_data", log_q[k].data, {40'h0, 8'h01, 8'h00, 8'(k)});
        end
        chk("t3_pkt_cnt", pkt_cnt, 32'd12);
        chk("t3_no_abort", abort_cnt, 16'd0);

        // lane 7 stalls after its sop beat
        log_q.delete();
        start(7, 2, 1, 0);
        lane_hold[7] = 1'b1;
        drive();
        #1;
        n = 0;
        while (log_q.size() < 1 && n < 10) begin
            tick();
            n++;
        end
        chk("t4_sop_beat", log_q.size(), 1);
        n = 0;
        while (!out_abort && n < 1100) begin
            tick();
            n++;
        end
        chk("t4_tmo_cycles", n, 1023);
        chk("t4_abort_beat", {out_valid, out_eop, out_abort, out_sop},
            4'b1110);
        chk("t4_abort_data", out_data, 64'h0);
        chk("t4_abort_proto", out_proto, 4'd7);
        chk("t4_abort_ready", req_ready, 8'h00);
        tick();
        chk("t4_abort_cnt", abort_cnt, 16'd1);
        chk("t4_grant_clr", grant, 8'h00);
        chk("t4_pkt_same", pkt_cnt, 32'd12);
        lane_hold[7] = 1'b0;
        drive();
        #1;
        chk("t4_drop_ready", req_ready, 8'h80);
        chk("t4_drop_novalid", out_valid, 1'b0);
        tick();
        chk("t4_drop_cnt", drop_cnt, 16'd1);
        chk("t4_grant_idle", grant, 8'h00);

        // stray non-sop beat on lane 6
        start(6, 2, 1, 1);
        drive();
        #1;
        chk("t5_drop_ready", req_ready, 8'h40);
        chk("t5_novalid", out_valid, 1'b0);
        tick();
        chk("t5_drop_cnt", drop_cnt, 16'd2);
        chk("t5_ready_off", req_ready, 8'h00);
        chk("t5_grant", grant, 8'h00);

        // reset in the middle of a lane 2 packet
        start(2, 4, 1, 0);
        drive();
        #1;
        tick();
        chk("t6_grant2", grant, 8'h04);
        tick();
        chk("t6_mid_valid", out_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        chk("t6_rst_grant", grant, 8'h00);
        chk("t6_rst_valid", out_valid, 1'b0);
        chk("t6_rst_cnt", pkt_cnt, 32'd0);
        for (int i = 0; i < 8; i++) lane_act[i] = 1'b0;
        start(0, 1, 1, 0);
        start(2, 1, 1, 0);
        drive();
        #1;
        tick();
        chk("t6_ptr_reset", grant, 8'h01);
        tick();
        chk("t6_pkt_after", pkt_cnt, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/parser_match_arbiter.md
Name: parser_match_arbiter

Overview:
- Packet-atomic round-robin arbiter sharing the single downstream content-match engine among the per-protocol payload extractors (one requester lane per protocol_type: ETH, IPV4, TCP, UDP, HTTP, TCP_INSPECT, TCP_SEGMENT, TCP_PAYLOAD).
- Once a lane wins, its grant is held until end-of-packet, so match state never interleaves across packets.
- Tags each beat with the protocol index, aborts stalled lanes after a timeout, and discards stray mid-packet beats.

Parameters:
- NUM_REQ, 8, requester lanes (equals NUM_PROTOCOLS).
- DATA_W, 64, payload beat width.
- TIMEOUT, 1023, idle cycles allowed inside a granted packet before abort.
- CNT_W, 10, timeout counter width (2^CNT_W > TIMEOUT).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-lane beat valid.
- req_sop  in  NUM_REQ  per-lane start-of-packet.
- req_eop  in  NUM_REQ  per-lane end-of-packet.
- req_data  in  NUM_REQ*DATA_W  lane i occupies bits [i*DATA_W +: DATA_W].
- req_ready  out  NUM_REQ  per-lane accept.
- out_valid  out  1  beat to match engine.
- out_data  out  DATA_W  beat data.
- out_sop  out  1  start-of-packet.
- out_eop  out  1  end-of-packet.
- out_abort  out  1  qualifies out_eop: packet truncated.
- out_proto  out  4  granted lane index (protocol_type value).
- out_ready  in  1  match engine accept.
- grant  out  NUM_REQ  one-hot current grant, 0 when idle.
- pkt_cnt  out  32  completed (non-aborted) packets.
- abort_cnt  out  16  aborted packets.
- drop_cnt  out  16  discarded stray beats.

Behaviour:
- Transfer rule: a beat moves when valid and ready are both high on the same edge. A requester must hold valid and data stable until ready.
- Reset values: state IDLE; grant 0; req_ready 0; out_valid/sop/eop/abort 0; out_data 0; out_proto 0; rr pointer NUM_REQ-1, so lane 0 has first priority; all counters 0. Reset mid-packet drops the packet silently, with no abort beat.
- FSM state IDLE:
  - Candidates are lanes with req_valid & req_sop.
  - Winner is the first candidate searching from pointer+1 upward with wrap-around.
  - Winner is registered into grant, pointer is set to the winner, and next state is STREAM. No data transfers in this cycle (1-cycle arbitration bubble).
  - If no candidate exists, the lowest-index lane with req_valid & !req_sop gets req_ready=1 for one cycle. The beat is discarded and drop_cnt increments (saturating).
- FSM state STREAM (lane g):
  - Combinational passthrough: out_valid=req_valid[g]; out_data/sop/eop from lane g; out_proto=g; req_ready[g]=out_ready; all other req_ready=0. Zero latency.
  - On a transfer with req_eop[g]=1: pkt_cnt++ (wraps), grant←0, next state IDLE. A single-beat packet (sop and eop together) completes this way.
  - Timeout counter clears on every transfer. It increments only on cycles with req_valid[g]=0; out_ready-low stalls do not count.
  - Counter reaching TIMEOUT sends the FSM to ABORT.
  - A sop beat from lane g mid-packet is passed through unchanged; checking it is the engine's responsibility.
- FSM state ABORT:
  - Drives out_valid=1, out_eop=1, out_abort=1, out_sop=0, out_data=0, out_proto=g; all req_ready=0.
  - Holds until out_ready. On that transfer: abort_cnt++ (saturating), grant←0, state IDLE.
  - Lane g's remaining beats later arrive without sop and are dropped in IDLE.
- Fairness: a lane requesting continuously waits at most NUM_REQ-1 packets.
- Grant changes only in IDLE; a new sop on another lane never preempts.

Test Plan:
- Reset, then lanes 0,2,5 each present 3-beat packets simultaneously → output order 0,2,5. Each packet is contiguous, 1 idle cycle between packets, out_proto=0,2,5, pkt_cnt=3.
- Lanes 3 and 4 request continuously, 1-beat packets → grants alternate 3,4,3,4; never two consecutive grants to one lane while the other waits.
- Lane 1 granted, out_ready toggled 50% during a 6-beat packet → all 6 beats delivered in order. req_ready[1] mirrors out_ready; timeout never fires.
- Lane 7 sends sop beat then req_valid low for 1023 cycles → abort beat (eop=1, abort=1, data=0, proto=7), abort_cnt=1. A later non-sop beat on lane 7 is dropped with drop_cnt=1.
- Lane 6 sends non-sop beat while IDLE and no sop pending → req_ready[6] high 1 cycle, nothing on output, drop_cnt increments.
- rst asserted in the middle of a lane 2 packet → next cycle grant=0, out_valid=0, pointer reset; after release, lane 0 wins over lane 2 on a simultaneous request.
